// File: rtl/mem_pkg.sv
// Purpose: shared defaults, row type and sequencer state encoding for the SRAM read path.
// Latency: n/a (types, constants and one combinational helper only).
// Backpressure: n/a.
package mem_pkg;

  localparam int DEF_NUM_BANK   = 16;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_SRAM_DEPTH = 256;
  localparam int DEF_ROW_BITS   = $clog2(DEF_SRAM_DEPTH);

  // One vector row: a word from every bank, bank i in element [i].
  typedef logic [DEF_NUM_BANK-1:0][DEF_DATA_WIDTH-1:0] row_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // A new read may go out only if, after this cycle's pop, the rows already
  // buffered plus the row coming back from the SRAM leave a free FIFO slot.
  function automatic logic can_issue(input logic [1:0] occ,
                                     input logic       inflight,
                                     input logic       pop);
    return ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  endfunction

endpackage

// File: rtl/mem_rd_fifo.sv
// Purpose: 2-entry FIFO holding returned SRAM rows plus their last tag.
// Latency: 1 cycle push-to-head; head is a registered slot.
// Backpressure: head holds while pop=0; push into a full FIFO without a pop is illegal.
//
// Ports: push/push_dat write an entry, pop retires the head,
//        head_vld/head_dat expose the oldest entry, occ is the entry count (0..2).
module mem_rd_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             head_vld,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] slot_q [2];
  logic [WIDTH-1:0] slot_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             do_pop;

  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    do_pop   = pop && (occ_q != 2'd0);

    // When full, wr_ptr equals rd_ptr: the head is read out this cycle from
    // slot_q before the same slot is overwritten, so push+pop on full is safe.
    if (push) begin
      slot_d[wr_ptr_q] = push_dat;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    if (push && !do_pop) begin
      occ_d = occ_q + 2'd1;
    end else if (!push && do_pop) begin
      occ_d = occ_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      slot_q[0] <= slot_d[0];
      slot_q[1] <= slot_d[1];
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
    end
  end

  assign head_dat = slot_q[rd_ptr_q];
  assign head_vld = (occ_q != 2'd0);
  assign occ      = occ_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(push && (occ_q == 2'd2) && !pop));

endmodule

// File: rtl/mem_rd_seq.sv
// Purpose: command-driven row read sequencer in front of a banked 1-cycle SRAM.
// Latency: first out_valid 2 cycles after command acceptance; 1 row/cycle sustained.
// Backpressure: out_valid/out_ready stream; reads stall on credit, nothing is dropped.
//
// Ports: cmd_valid/cmd_ready + cmd_base/cmd_len/cmd_stride accept a command;
//        rd_en/rd_addr drive all banks, rd_data returns one cycle later;
//        out_valid/out_ready/out_data/out_last carry rows; busy and done report progress.
module mem_rd_seq
  import mem_pkg::*;
#(
  parameter int NUM_BANK   = DEF_NUM_BANK,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int SRAM_DEPTH = DEF_SRAM_DEPTH
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic [ADDR_WIDTH-1:0]                cmd_base,
  input  logic [ADDR_WIDTH-1:0]                cmd_len,
  input  logic [ADDR_WIDTH-1:0]                cmd_stride,
  output logic [NUM_BANK-1:0]                  rd_en,
  output logic [NUM_BANK-1:0][ADDR_WIDTH-1:0]  rd_addr,
  input  logic [NUM_BANK-1:0][DATA_WIDTH-1:0]  rd_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [NUM_BANK-1:0][DATA_WIDTH-1:0]  out_data,
  output logic                                 out_last,
  output logic                                 busy,
  output logic                                 done
);

  localparam int                    FIFO_W   = NUM_BANK * DATA_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] ROW_MASK = ADDR_WIDTH'(SRAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [ADDR_WIDTH-1:0] issued_q, issued_d;
  logic [ADDR_WIDTH-1:0] rd_row_q, rd_row_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic                  done_q, done_d;

  logic                  issue;
  logic                  last_row;
  logic                  pop;
  logic                  credit;
  logic [1:0]            fifo_occ;
  logic [FIFO_W-1:0]     fifo_head;
  logic                  fifo_vld;

  assign pop      = out_valid & out_ready;
  assign credit   = can_issue(fifo_occ, inflight_q, pop);
  assign last_row = (issued_q == len_q - ONE);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    stride_d  = stride_q;
    issued_d  = issued_q;
    done_d    = 1'b0;
    issue     = 1'b0;
    cmd_ready = 1'b0;
    busy      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Held low during the done pulse so the next command lands a cycle later.
        cmd_ready = ~done_q;
        if (cmd_valid && !done_q) begin
          if (cmd_len != '0) begin
            addr_d   = cmd_base;
            len_d    = cmd_len;
            stride_d = cmd_stride;
            issued_d = '0;
            state_d  = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        busy = 1'b1;
        if (credit) begin
          issue    = 1'b1;
          addr_d   = addr_q + stride_q;
          issued_d = issued_q + ONE;
          if (last_row) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        busy = 1'b1;
        if (pop && out_last) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Row address is held between issues so rd_addr does not toggle when idle.
  always_comb begin
    rd_row_d        = issue ? (addr_q & ROW_MASK) : rd_row_q;
    inflight_d      = issue;
    inflight_last_d = issue & last_row;
    for (int i = 0; i < NUM_BANK; i++) begin
      rd_en[i]   = issue;
      rd_addr[i] = rd_row_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      len_q           <= '0;
      stride_q        <= '0;
      issued_q        <= '0;
      rd_row_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      len_q           <= len_d;
      stride_q        <= stride_d;
      issued_q        <= issued_d;
      rd_row_q        <= rd_row_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
    end
  end

  // rd_data is only meaningful the cycle after an issue; capture it then.
  mem_rd_fifo #(
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (inflight_q),
    .push_dat ({rd_data, inflight_last_q}),
    .pop      (pop),
    .head_dat (fifo_head),
    .head_vld (fifo_vld),
    .occ      (fifo_occ)
  );

  assign out_valid = fifo_vld;
  assign out_data  = fifo_head[FIFO_W-1:1];
  assign out_last  = fifo_vld & fifo_head[0];
  assign done      = done_q;

endmodule

// File: tb/tb_mem_rd_seq.sv
module tb_mem_rd_seq;
  import mem_pkg::*;

  localparam int NB = DEF_NUM_BANK;
  localparam int DW = DEF_DATA_WIDTH;
  localparam int AW = DEF_ADDR_WIDTH;
  localparam int SD = DEF_SRAM_DEPTH;

  logic                   clk;
  logic                   rstn;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [AW-1:0]          cmd_base;
  logic [AW-1:0]          cmd_len;
  logic [AW-1:0]          cmd_stride;
  logic [NB-1:0]          rd_en;
  logic [NB-1:0][AW-1:0]  rd_addr;
  row_t                   rd_data;
  logic                   out_valid;
  logic                   out_ready;
  row_t                   out_data;
  logic                   out_last;
  logic                   busy;
  logic                   done;

  int n_tests = 0;
  int n_fail  = 0;

  mem_rd_seq dut (
    .clk        (clk),
    .rstn       (rstn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_base   (cmd_base),
    .cmd_len    (cmd_len),
    .cmd_stride (cmd_stride),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Preloaded SRAM contents, distinct per bank and row.
  function automatic logic [DW-1:0] pat(input int b, input int r);
    return DW'((b * 4099 + r * 131 + 23) % 65536);
  endfunction

  // Banked SRAM: one-cycle read latency per bank.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (rd_en[b]) rd_data[b] <= pat(b, int'(rd_addr[b]) % SD);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input int base, input int len, input int stride);
    @(negedge clk);
    cmd_base   = AW'(base);
    cmd_len    = AW'(len);
    cmd_stride = AW'(stride);
    cmd_valid  = 1'b1;
    for (int w = 0; w < 20 && !cmd_ready; w++) @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_accept: cmd_ready=%b, required 1 within 20 cycles", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Runs one command and checks issue order, data, tags, occupancy, done timing.
  // mode 0: out_ready=1; mode 1: out_ready=0 for 6 cycles then 1; mode 2: random.
  task automatic run_stream(input int base, input int len, input int stride,
                            input int mode, input string name);
    int   exp_rows[$];
    int   issued, popped, iter, last_pop_iter, first_valid_iter, dones, stalled_iss;
    bit   finished, held_vld, held_last, ok;
    row_t held_dat;

    for (int k = 0; k < len; k++) exp_rows.push_back(((base + k * stride) % 65536) % SD);
    issued = 0; popped = 0; iter = 0; last_pop_iter = -1; first_valid_iter = -1;
    dones = 0; stalled_iss = 0; finished = 0; held_vld = 0; held_last = 0; held_dat = '0;

    send_cmd(base, len, stride);
    while (!finished && iter < len * 8 + 40) begin
      if (iter > 0) @(negedge clk);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (iter >= 6);
        default: out_ready = ($urandom_range(0, 9) < 6);
      endcase
      #1;

      if (rd_en !== '0) begin
        ok = (rd_en === '1) && (issued < len);
        for (int b = 0; b < NB && ok; b++) ok = (int'(rd_addr[b]) == exp_rows[issued]);
        n_tests++;
        if (!ok) begin
          n_fail++;
          $display("FAIL %s issue %0d: rd_en=%h rd_addr[0]=%0d rd_addr[%0d]=%0d, required all-ones and row %0d",
                   name, issued, rd_en, rd_addr[0], NB-1, rd_addr[NB-1],
                   (issued < len) ? exp_rows[issued] : -1);
        end
        if (mode == 0) begin
          n_tests++;
          if (iter != issued) begin
            n_fail++;
            $display("FAIL %s issue_cycle %0d: at cycle %0d, required cycle %0d", name, issued, iter, issued);
          end
        end
        if (mode == 1 && iter < 6) stalled_iss++;
        issued++;
      end

      if (held_vld) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== held_dat || out_last !== held_last) begin
          n_fail++;
          $display("FAIL %s stall_hold: valid=%b last=%b data0=%h, required 1 %b %h",
                   name, out_valid, out_last, out_data[0], held_last, held_dat[0]);
        end
      end

      if (out_valid === 1'b1) begin
        if (first_valid_iter < 0) first_valid_iter = iter;
        if (out_ready) begin
          ok = (popped < len);
          for (int b = 0; b < NB && ok; b++) ok = (out_data[b] === pat(b, exp_rows[popped]));
          ok = ok && (out_last === (popped == len - 1));
          n_tests++;
          if (!ok) begin
            n_fail++;
            $display("FAIL %s beat %0d: data0=%h last=%b, required %h %b", name, popped,
                     out_data[0], out_last, (popped < len) ? pat(0, exp_rows[popped]) : '0,
                     (popped == len - 1));
          end
          popped++;
          if (popped == len) last_pop_iter = iter;
        end
      end
      held_vld  = (out_valid === 1'b1) && !out_ready;
      held_dat  = out_data;
      held_last = out_last;

      n_tests++;
      if (issued - popped > 2 || issued < popped) begin
        n_fail++;
        $display("FAIL %s occupancy: issued-popped=%0d, required 0..2", name, issued - popped);
      end

      if (done === 1'b1) dones++;
      if (last_pop_iter < 0 || iter <= last_pop_iter) begin
        n_tests++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL %s busy: busy=%b cmd_ready=%b at cycle %0d, required 1 0", name, busy, cmd_ready, iter);
        end
      end else if (iter == last_pop_iter + 1) begin
        n_tests++;
        if (done !== 1'b1 || cmd_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL %s done_pulse: done=%b cmd_ready=%b, required 1 0", name, done, cmd_ready);
        end
      end else begin
        n_tests++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s idle_after: cmd_ready=%b busy=%b done=%b out_valid=%b, required 1 0 0 0",
                   name, cmd_ready, busy, done, out_valid);
        end
        finished = 1;
      end
      iter++;
    end

    n_tests++;
    if (!finished || dones != 1 || issued != len || popped != len) begin
      n_fail++;
      $display("FAIL %s totals: finished=%0d dones=%0d issued=%0d popped=%0d, required 1 1 %0d %0d",
               name, finished, dones, issued, popped, len, len);
    end
    if (mode == 0) begin
      n_tests++;
      if (first_valid_iter != 2 || last_pop_iter != len + 1) begin
        n_fail++;
        $display("FAIL %s throughput: first_valid=%0d last_pop=%0d, required 2 %0d",
                 name, first_valid_iter, last_pop_iter, len + 1);
      end
    end
    if (mode == 1) begin
      n_tests++;
      if (stalled_iss != 2) begin
        n_fail++;
        $display("FAIL %s stalled_issues: %0d, required 2", name, stalled_iss);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    n_tests++;
    if (cmd_ready !== 1'b1 || rd_en !== '0 || rd_addr !== '0 || out_valid !== 1'b0 ||
        out_data !== '0 || out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: cmd_ready=%b rd_en=%h addr0=%0d valid=%b data0=%h last=%b busy=%b done=%b, required 1 0 0 0 0 0 0 0",
               name, cmd_ready, rd_en, rd_addr[0], out_valid, out_data[0], out_last, busy, done);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rstn = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs("after_release");
  endtask

  task automatic test_basic();
    run_stream(0, 4, 1, 0, "basic");
  endtask

  task automatic test_wrap();
    run_stream(250, 10, 1, 0, "wrap");
  endtask

  task automatic test_stall();
    run_stream(0, 3, 5, 1, "stall");
  endtask

  task automatic test_zero_len();
    send_cmd(33, 0, 1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_tests++;
      if (done !== (i == 0) || rd_en !== '0 || busy !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_len cycle %0d: done=%b rd_en=%h busy=%b valid=%b, required %b 0 0 0",
                 i, done, rd_en, busy, out_valid, (i == 0));
      end
    end
  endtask

  task automatic test_random_ready();
    run_stream($urandom_range(0, 65535), 64, 3, 2, "random_ready");
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 6; c++) begin
      run_stream($urandom_range(0, 65535), $urandom_range(1, 20), $urandom_range(0, 65535),
                 (c % 2 == 0) ? 2 : 0, "back_to_back");
    end
  endtask

  task automatic test_reset_mid_run();
    int pops;
    pops = 0;
    send_cmd(40, 8, 1);
    for (int i = 0; i < 30 && pops < 2; i++) begin
      if (i > 0) @(negedge clk);
      out_ready = 1'b1;
      #1;
      if (out_valid === 1'b1) pops++;
    end
    n_tests++;
    if (pops != 2) begin
      n_fail++;
      $display("FAIL mid_run_pops: %0d, required 2 before reset", pops);
    end
    rstn = 1'b0;
    #1;
    check_reset_outputs("mid_run_reset");
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check_reset_outputs("mid_run_release");
    run_stream(7, 2, 1, 0, "post_reset");
  endtask

  initial begin
    cmd_valid  = 1'b0;
    cmd_base   = '0;
    cmd_len    = '0;
    cmd_stride = '0;
    out_ready  = 1'b0;
    rstn       = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_zero_len();
    test_random_ready();
    test_back_to_back();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_rd_seq.md
Name: mem_rd_seq

Overview:
- Read-side sequencer placed directly upstream of the banked SRAM array (NUM_BANK banks, each with a 1-cycle-latency read port).
- Accepts a command (base row, row count, stride) and issues one vector row read per cycle to all banks.
- Captures the returned bank data and presents it on a valid/ready stream.
- Issues reads under credit control: raw SRAM read data is never held, so a read is issued only when output buffering is guaranteed.

Parameters:
- NUM_BANK, 16, number of banks read in parallel.
- DATA_WIDTH, 16, bits per bank word.
- ADDR_WIDTH, 16, width of the command and rd_addr fields.
- SRAM_DEPTH, 256, rows per bank. Power of two; row addresses wrap modulo this value.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_base  in  ADDR_WIDTH  first row address.
- cmd_len  in  ADDR_WIDTH  number of rows to read.
- cmd_stride  in  ADDR_WIDTH  row increment between reads.
- rd_en  out  NUM_BANK  per-bank read enable.
- rd_addr  out  ADDR_WIDTH x [0:NUM_BANK-1]  per-bank read row address.
- rd_data  in  DATA_WIDTH x [0:NUM_BANK-1]  bank read data, valid 1 cycle after rd_en.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  DATA_WIDTH x [0:NUM_BANK-1]  one row from every bank.
- out_last  out  1  final row of the command.
- busy  out  1  command in progress.
- done  out  1  single-cycle pulse when a command completes.

Interface rules:
- One clock; reset is asynchronous and active-low.
- Port names: clk and rstn.

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE, counters=0, FIFO empty, in-flight flag=0. All outputs 0 except cmd_ready=1. Any in-flight read data is discarded. Reset may arrive in any state.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid with cmd_len!=0: latch base/len/stride, addr=base, issued=0, go to RUN.
  - On cmd_valid with cmd_len==0: command accepted, done=1 next cycle, stay IDLE, no reads issued.
- RUN:
  - cmd_ready=0, busy=1.
  - Issue condition: credit = (fifo_occ + inflight - pop) < 2, where pop = out_valid & out_ready in the same cycle.
  - On issue: rd_en=all ones, rd_addr[i]=addr & (SRAM_DEPTH-1) for every i; addr += stride (mod 2^ADDR_WIDTH); issued++.
  - On the cycle issuing row len-1, go to DRAIN.
  - rd_en=0 whenever no issue occurs. rd_addr holds its last value and is don't-care.
- DRAIN: busy=1, no issue. When the beat tagged last is popped: done=1 for 1 cycle, go to IDLE. cmd_ready becomes 1 the cycle after done.
- Return path:
  - A registered inflight bit (plus a last tag) follows each issue by exactly 1 cycle.
  - In the cycle inflight=1, rd_data is written into a 2-entry output FIFO along with the last tag.
  - The FIFO head drives out_data/out_valid/out_last.
  - The credit rule guarantees the FIFO never overflows; overflow is an assertion failure.
- Throughput: with out_ready held at 1, one row per cycle.
  - First out_valid appears 2 cycles after command acceptance (issue cycle +1 for SRAM, +1 FIFO write).
  - A command of length N completes with done 1 cycle after the N-th pop.
- Backpressure: out_data and out_last stay stable while out_valid=1 and out_ready=0. Issue stalls once the credit limit is reached; no data is lost.
- Address arithmetic: full ADDR_WIDTH add with wrap. Only the low log2(SRAM_DEPTH) bits are driven meaningfully; upper rd_addr bits = 0.
- Simultaneous push and pop on the same cycle, including when the FIFO is full: both happen and occupancy is unchanged.
- cmd_valid while busy: ignored (cmd_ready=0). The command must be held until accepted.

Decomposition:
- Shared package mem_pkg:
  - NUM_BANK, DATA_WIDTH, ADDR_WIDTH, SRAM_DEPTH defaults.
  - row_t typedef (array of NUM_BANK words).
  - FSM state enum.
- Sub-module: mem_rd_fifo, a parameterised 2-entry FIFO carrying {row_t, last} with occupancy output.

Test Plan:
- base=0, len=4, stride=1, out_ready=1 -> rd_addr 0,1,2,3 on consecutive cycles. 4 beats, each bank's data matches a preloaded pattern. out_last on beat 4; done 1 cycle after beat 4.
- base=250, len=10, stride=1 -> addresses 250..255 then 0..3 (wrap at SRAM_DEPTH); 10 beats in order.
- len=3, stride=5, out_ready=0 for 6 cycles then 1 -> at most 2 reads issued while stalled; out_data stable during the stall; beats for rows 0,5,10 delivered without loss or duplication.
- cmd_len=0 -> no rd_en asserted, done pulse 1 cycle after acceptance, busy stays 0.
- Random out_ready toggling, len=64, stride=3 -> scoreboard matches all 64 rows in order; FIFO occupancy never exceeds 2.
- rstn deasserted mid-RUN, 2 beats into len=8 -> outputs return to reset values immediately. A new command (base=7, len=2) then runs cleanly with no stale beats.
